// File: rtl/wb_regfile.sv
// Y86-64 SEQ write-back register file: destination decode, commit, two async read ports,
// sticky halt and retired-instruction counter. Define WB_BYPASS_EN to forward write data to reads.
module wb_regfile #(
    parameter int NREG = 15,
    parameter int DW   = 64,
    parameter int CNTW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [3:0]      icode,
    input  logic [3:0]      rA,
    input  logic [3:0]      rB,
    input  logic            cnd,
    input  logic [DW-1:0]   valE,
    input  logic [DW-1:0]   valM,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    output logic [DW-1:0]   rdA,
    output logic [DW-1:0]   rdB,
    output logic            halted,
    output logic [CNTW-1:0] instr_cnt
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic            halted_q, halted_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       stop;
    logic       commit;

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        stop  = 1'b0;
        case (icode)
            4'h2: dst_e = cnd ? rB : RNONE;
            4'h3, 4'h6: dst_e = rB;
            4'h5: dst_m = rA;
            4'h8, 4'h9, 4'hA: dst_e = RSP;
            4'hB: begin
                dst_e = RSP;
                dst_m = rA;
            end
            4'h0, 4'hC, 4'hD, 4'hE, 4'hF: stop = 1'b1;
            default: ;
        endcase
    end

    assign commit = wb_valid && !halted_q;

    // dstM is applied after dstE so popq %rsp keeps the popped value
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && dst_e == 4'(i)) regs_d[i] = valE;
            if (commit && dst_m == 4'(i)) regs_d[i] = valM;
        end
        halted_d = halted_q | (commit && stop);
        cnd_cnt_update();
    end

    function automatic void cnd_cnt_update();
        cnt_d = commit ? cnt_q + {{(CNTW-1){1'b0}}, 1'b1} : cnt_q;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        rdA = '0;
        rdB = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i)) rdA = regs_q[i];
            if (srcB == 4'(i)) rdB = regs_q[i];
        end
`ifdef WB_BYPASS_EN
        // valM outranks valE, which outranks the array; RNONE never matches
        if (commit && srcA != RNONE) begin
            if (dst_e == srcA) rdA = valE;
            if (dst_m == srcA) rdA = valM;
        end
        if (commit && srcB != RNONE) begin
            if (dst_e == srcB) rdB = valE;
            if (dst_m == srcB) rdB = valM;
        end
`endif
    end

    assign halted    = halted_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: commit decode, popq priority, cmov,
// halt/illegal stop, async reset and the optional read bypass.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  icode, rA, rB, srcA, srcB;
    logic        cnd;
    logic [63:0] valE, valM;
    logic [63:0] rdA, rdB;
    logic        halted;
    logic [63:0] instr_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode),
        .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
        .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB),
        .halted(halted), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm);
        icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
        wb_valid = 1'b1;
    endtask

    task automatic step(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve, input logic [63:0] vm);
        drive(ic, ra, rb, c, ve, vm);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] addr, input logic [63:0] exp);
        srcA = addr;
        srcB = addr;
        #1;
        check({tag, "_A"}, rdA, exp);
        check({tag, "_B"}, rdB, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
        cnd = 1'b0; valE = '0; valM = '0; srcA = 4'hF; srcB = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_halted", {63'd0, halted}, 64'd0);
        check("reset_cnt", instr_cnt, 64'd0);
        rd("reset_r3", 4'h3, 64'd0);

        // irmovq
        step(4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0);
        rd("irmovq_r3", 4'h3, 64'h1234);
        check("irmovq_cnt", instr_cnt, 64'd1);

        // popq %rsp: valM wins
        step(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hBEEF);
        rd("popq_rsp", 4'h4, 64'hBEEF);
        step(4'hB, 4'h2, 4'hF, 1'b0, 64'hF8, 64'h55);
        rd("popq_r4", 4'h4, 64'hF8);
        rd("popq_r2", 4'h2, 64'h55);
        check("popq_cnt", instr_cnt, 64'd3);

        // cmovXX
        step(4'h2, 4'hF, 4'h5, 1'b0, 64'h7, 64'h0);
        rd("cmov_nc", 4'h5, 64'h0);
        step(4'h2, 4'hF, 4'h5, 1'b1, 64'h7, 64'h0);
        rd("cmov_c", 4'h5, 64'h7);
        check("cmov_cnt", instr_cnt, 64'd5);

        // OPq, call, mrmovq, rmmovq
        step(4'h6, 4'hF, 4'h7, 1'b0, 64'h77, 64'h0);
        rd("opq_r7", 4'h7, 64'h77);
        step(4'h8, 4'hF, 4'hF, 1'b0, 64'h3F0, 64'h0);
        rd("call_rsp", 4'h4, 64'h3F0);
        step(4'h5, 4'h8, 4'hF, 1'b0, 64'h0, 64'hAB);
        rd("mrmovq_r8", 4'h8, 64'hAB);
        step(4'h4, 4'h9, 4'h9, 1'b0, 64'h99, 64'h99);
        rd("rmmovq_r9", 4'h9, 64'h0);
        rd("rnone", 4'hF, 64'h0);
        check("mixed_cnt", instr_cnt, 64'd9);

        // same-cycle read of a register being written
        step(4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0);
        drive(4'h5, 4'h6, 4'hF, 1'b0, 64'h0, 64'hAA);
        srcA = 4'h6; srcB = 4'h6;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_A", rdA, 64'hAA);
        check("bypass_B", rdB, 64'hAA);
`else
        check("nobypass_A", rdA, 64'h66);
        check("nobypass_B", rdB, 64'h66);
`endif
        @(posedge clk);
        #1 wb_valid = 1'b0;
        rd("after_edge_r6", 4'h6, 64'hAA);
        check("pre_halt_cnt", instr_cnt, 64'd11);

        // halt blocks later writes and counting
        step(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        check("halt_flag", {63'd0, halted}, 64'd1);
        step(4'h3, 4'hF, 4'h1, 1'b0, 64'h9, 64'h0);
        rd("halted_r1", 4'h1, 64'h0);
        check("halted_cnt", instr_cnt, 64'd12);

        rst = 1'b1;
        #1;
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_cnt", instr_cnt, 64'd0);
        rd("rst_r6", 4'h6, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // async reset with a write pending
        step(4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0);
        rd("pre5_r3", 4'h3, 64'h1234);
        drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h99, 64'h0);
        #1 rst = 1'b1;
        #1;
        check("midrst_r3", rdA, 64'h0);
        check("midrst_cnt", instr_cnt, 64'd0);
        @(posedge clk);
        #1;
        check("rst_edge_r3", rdA, 64'h0);
        check("rst_edge_cnt", instr_cnt, 64'd0);
        wb_valid = 1'b0;
        rst = 1'b0;

        // illegal icode stops like halt, no write
        step(4'hC, 4'h3, 4'h3, 1'b1, 64'h5, 64'h5);
        rd("illegal_r3", 4'h3, 64'h0);
        check("illegal_halt", {63'd0, halted}, 64'd1);
        check("illegal_cnt", instr_cnt, 64'd1);

        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'h3, 4'hF, 4'h2, 1'b0, 64'h22, 64'h0);
        rd("first_write_r2", 4'h2, 64'h22);
        check("first_write_cnt", instr_cnt, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
